// File: rtl/risc16_iter_alu.sv
// Iterative 16-bit-class ALU: single-cycle ADD/NAND/PASSA/SUB, bit-serial SHL/SHR,
// and an optional shift-add multiplier built only when RISC16_ALU_MUL_EN is defined.
module risc16_iter_alu #(
    parameter int WORD_LENGTH = 16,
    parameter int SHAMT_LEN   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             funct,
    input  logic [WORD_LENGTH-1:0] src1,
    input  logic [WORD_LENGTH-1:0] src2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] result,
    output logic                   state,
    output logic                   illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    localparam int CNT_W = SHAMT_LEN + 1;

    localparam logic [2:0] F_ADD   = 3'b000;
    localparam logic [2:0] F_NAND  = 3'b001;
    localparam logic [2:0] F_PASSA = 3'b010;
    localparam logic [2:0] F_SUB   = 3'b011;
    localparam logic [2:0] F_SHL   = 3'b100;
    localparam logic [2:0] F_SHR   = 3'b101;
    localparam logic [2:0] F_MUL   = 3'b110;
    localparam logic [2:0] F_ILL   = 3'b111;

`ifdef RISC16_ALU_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    function automatic logic [WORD_LENGTH-1:0] alu_op(
        input logic [2:0]             f,
        input logic [WORD_LENGTH-1:0] a,
        input logic [WORD_LENGTH-1:0] b
    );
        case (f)
            F_ADD:   return a + b;
            F_NAND:  return ~(a & b);
            F_PASSA: return a;
            F_SUB:   return a - b;
            default: return {WORD_LENGTH{1'b0}};
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] f);
        return (f == F_ILL) || (!MUL_EN && (f == F_MUL));
    endfunction

    function automatic logic zero_flag(input logic [WORD_LENGTH-1:0] v);
        return ~|v;
    endfunction

    fsm_e                   fsm_q,       fsm_d;
    logic [2:0]             funct_q,     funct_d;
    logic [WORD_LENGTH-1:0] a_q,         a_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [WORD_LENGTH-1:0] result_q,    result_d;
    logic                   state_q,     state_d;
    logic                   illegal_q,   illegal_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [WORD_LENGTH-1:0] op_s;
    logic [WORD_LENGTH-1:0] step_s;
    logic [WORD_LENGTH-1:0] fin_s;

`ifdef RISC16_ALU_MUL_EN
    logic [WORD_LENGTH-1:0] acc_q, acc_d;
    logic [WORD_LENGTH-1:0] b_q,   b_d;
    logic [WORD_LENGTH-1:0] mul_sum_s;

    // Partial-product accumulation: multiplicand shifts left, multiplier bit 0 gates the add.
    assign mul_sum_s = b_q[0] ? (acc_q + a_q) : acc_q;
`endif

    // Result of the single-cycle opcodes, computed straight from the request.
    assign op_s = alu_op(funct, src1, src2);

    // Next-state, datapath and output-flag decode.
    always_comb begin
        fsm_d     = fsm_q;
        funct_d   = funct_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        state_d   = state_q;
        illegal_d = illegal_q;
        step_s    = a_q;
        fin_s     = a_q;
`ifdef RISC16_ALU_MUL_EN
        acc_d     = acc_q;
        b_d       = b_q;
`endif
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    funct_d = funct;
                    a_d     = src1;
                    if ((funct == F_SHL) || (funct == F_SHR)) begin
                        cnt_d = {1'b0, src2[SHAMT_LEN-1:0]};
                        if (src2[SHAMT_LEN-1:0] == {SHAMT_LEN{1'b0}}) begin
                            fsm_d     = S_DONE;
                            result_d  = src1;
                            state_d   = zero_flag(src1);
                            illegal_d = 1'b0;
                        end else begin
                            fsm_d = S_BUSY;
                        end
                    end
`ifdef RISC16_ALU_MUL_EN
                    else if (funct == F_MUL) begin
                        cnt_d = CNT_W'(WORD_LENGTH);
                        acc_d = {WORD_LENGTH{1'b0}};
                        b_d   = src2;
                        fsm_d = S_BUSY;
                    end
`endif
                    else begin
                        fsm_d     = S_DONE;
                        result_d  = op_s;
                        state_d   = zero_flag(op_s);
                        illegal_d = is_illegal(funct);
                    end
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d  = cnt_q - CNT_W'(1);
                step_s = (funct_q == F_SHL) ? (a_q << 1) : (a_q >> 1);
                a_d    = step_s;
                fin_s  = step_s;
`ifdef RISC16_ALU_MUL_EN
                if (funct_q == F_MUL) begin
                    acc_d = mul_sum_s;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    fin_s = mul_sum_s;
                end else begin
                    b_d = b_q;
                end
`endif
                // The last iteration is the one that brings the count to zero.
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d     = S_DONE;
                    result_d  = fin_s;
                    state_d   = zero_flag(fin_s);
                    illegal_d = 1'b0;
                end else begin
                    fsm_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end else begin
                    fsm_d = S_DONE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        in_ready_d  = (fsm_d == S_IDLE);
        out_valid_d = (fsm_d == S_DONE);
    end

    // State, datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= S_IDLE;
            funct_q     <= 3'b000;
            a_q         <= {WORD_LENGTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            result_q    <= {WORD_LENGTH{1'b0}};
            state_q     <= 1'b0;
            illegal_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            funct_q     <= funct_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef RISC16_ALU_MUL_EN
    // Multiplier accumulator and multiplier operand.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= {WORD_LENGTH{1'b0}};
            b_q   <= {WORD_LENGTH{1'b0}};
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign state     = state_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_risc16_iter_alu.sv
// Self-checking bench for risc16_iter_alu (WORD_LENGTH=16): directed and random
// operations against an arithmetic reference model; honours RISC16_ALU_MUL_EN.
module tb_risc16_iter_alu;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct;
    logic [15:0] src1;
    logic [15:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        state;
    logic        illegal;

    int vectors = 0;
    int errors  = 0;

    risc16_iter_alu #(.WORD_LENGTH(16), .SHAMT_LEN(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .state     (state),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        st;
        logic        il;
        int          lat;
    } vec_t;

    // Reference model straight from the operation definitions.
    task automatic model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic il, output int lat);
        int unsigned k;
        logic [31:0] p;
        k   = b % 16;
        r   = 16'h0000;
        il  = 1'b0;
        lat = 1;
        case (f)
            3'd0: r = a + b;
            3'd1: r = ~(a & b);
            3'd2: r = a;
            3'd3: r = a - b;
            3'd4: begin r = a << k; lat = 1 + k; end
            3'd5: begin r = a >> k; lat = 1 + k; end
`ifdef RISC16_ALU_MUL_EN
            3'd6: begin p = a * b; r = p[15:0]; lat = 17; end
`else
            3'd6: il = 1'b1;
`endif
            default: il = 1'b1;
        endcase
    endtask

    // Drives one request, measures latency, stalls the consumer and retires the result.
    task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                          input int stall, output int lat, output logic [15:0] r,
                          output logic st, output logic il, output bit ctl_ok);
        ctl_ok = 1'b1;
        if (in_ready !== 1'b1) ctl_ok = 1'b0;
        in_valid  = 1'b1;
        funct     = f;
        src1      = a;
        src2      = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        funct    = 3'($urandom);
        src1     = 16'($urandom);
        src2     = 16'($urandom);
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) ctl_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        r  = result;
        st = state;
        il = illegal;
        if (in_ready !== 1'b0) ctl_ok = 1'b0;
        repeat (stall) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (result !== r || state !== st || illegal !== il ||
                out_valid !== 1'b1 || in_ready !== 1'b0) ctl_ok = 1'b0;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) ctl_ok = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 ||
            state !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h state=%b illegal=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, result, state, illegal);
        end
    endtask

    task automatic test_directed();
        vec_t tbl[$];
        int lat;
        logic [15:0] r;
        logic st, il;
        bit ok;
        tbl.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1});
        tbl.push_back('{3'd3, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1});
        tbl.push_back('{3'd4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 16});
        tbl.push_back('{3'd5, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1});
        tbl.push_back('{3'd5, 16'hF0F0, 16'h0004, 16'h0F0F, 1'b0, 1'b0, 5});
        tbl.push_back('{3'd2, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1});
        tbl.push_back('{3'd7, 16'hABCD, 16'h1111, 16'h0000, 1'b1, 1'b1, 1});
`ifdef RISC16_ALU_MUL_EN
        tbl.push_back('{3'd6, 16'h0102, 16'h0003, 16'h0306, 1'b0, 1'b0, 17});
        tbl.push_back('{3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17});
`else
        tbl.push_back('{3'd6, 16'h0102, 16'h0003, 16'h0000, 1'b1, 1'b1, 1});
`endif
        foreach (tbl[i]) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, 1, lat, r, st, il, ok);
            vectors++;
            if (r !== tbl[i].r || st !== tbl[i].st || il !== tbl[i].il) begin
                errors++;
                $display("FAIL directed[%0d] f=%0d: got result=%h state=%b illegal=%b, want %h %b %b",
                         i, tbl[i].f, r, st, il, tbl[i].r, tbl[i].st, tbl[i].il);
            end
            vectors++;
            if (lat !== tbl[i].lat) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, tbl[i].lat);
            end
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL directed_handshake[%0d]: got ok=%b, want 1", i, ok);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [15:0] r;
        logic st, il;
        bit ok;
        run_op(3'd1, 16'hFFFF, 16'hFFFF, 5, lat, r, st, il, ok);
        vectors++;
        if (r !== 16'h0000 || st !== 1'b1 || il !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL hold_value: got result=%h state=%b illegal=%b lat=%0d, want 0000 1 0 1",
                     r, st, il, lat);
        end
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_stable: got ok=%b, want 1", ok);
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [15:0] a, b, er, r;
        logic        eil, st, il;
        int          elat, lat;
        bit          ok;
        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom);
            a = 16'($urandom);
            b = (n % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            model(f, a, b, er, eil, elat);
            run_op(f, a, b, $urandom_range(0, 3), lat, r, st, il, ok);
            vectors++;
            if (r !== er || st !== (er == 16'h0000) || il !== eil || lat !== elat || !ok) begin
                errors++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: got %h %b %b lat=%0d ok=%b, want %h %b %b lat=%0d ok=1",
                         n, f, a, b, r, st, il, lat, ok, er, (er == 16'h0000), eil, elat);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [15:0] r;
        logic st, il;
        bit ok;
        in_valid = 1'b1;
`ifdef RISC16_ALU_MUL_EN
        funct = 3'd6;
        src1  = 16'h1234;
        src2  = 16'h5678;
`else
        funct = 3'd4;
        src1  = 16'h1234;
        src2  = 16'h000F;
`endif
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1 ||
            state !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: out_valid=%b result=%h in_ready=%b state=%b illegal=%b, want 0 0000 1 0 0",
                     out_valid, result, in_ready, state, illegal);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(3'd0, 16'h0002, 16'h0003, 0, lat, r, st, il, ok);
        vectors++;
        if (r !== 16'h0005 || st !== 1'b0 || il !== 1'b0 || lat !== 1 || !ok) begin
            errors++;
            $display("FAIL abort_restart: got %h %b %b lat=%0d ok=%b, want 0005 0 0 lat=1 ok=1",
                     r, st, il, lat, ok);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        funct     = 3'd0;
        src1      = 16'h0000;
        src2      = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_hold();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
